// File: rtl/write_buffer.sv
// Posted-write FIFO between the cache memory port and main memory: writes are acked on
// queueing and drained in order; a read waits until every queued write has been committed.
module write_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_req,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [DATA_W-1:0] up_wdata,
    output logic              up_ready,
    output logic              up_done,
    output logic [DATA_W-1:0] up_rdata,
    output logic              dn_req,
    output logic              dn_we,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_wdata,
    input  logic              dn_ready,
    input  logic              dn_done,
    input  logic [DATA_W-1:0] dn_rdata,
    output logic [PTR_W:0]    wb_count,
    output logic              wb_empty,
    output logic              wb_full,
    output logic [1:0]        dbg_main_state,
    output logic              dbg_drain_state
);
    // Handshakes: up_req is taken in any cycle where up_ready=1 and is answered later by a
    // one-cycle up_done pulse. dn_req is a one-cycle issue made only while dn_ready=1; the
    // transaction ends with a one-cycle dn_done. Only one dn transaction is ever outstanding.

    typedef enum logic [1:0] {IDLE, W_FULL, R_WAIT_EMPTY, R_BUSY} main_state_t;
    typedef enum logic {D_IDLE, D_BUSY} drain_state_t;

    main_state_t       state_q, state_d;
    drain_state_t      dstate_q, dstate_d;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q;
    logic [ADDR_W-1:0] hold_addr_q, rd_addr_q;
    logic [DATA_W-1:0] hold_data_q;

    logic              push, pop, done_d;
    logic              latch_hold, latch_rd, capture_rd;
    logic              drain_issue, read_issue;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign wb_count        = count_q;
    assign wb_empty        = (count_q == '0);
    assign wb_full         = (count_q == (PTR_W+1)'(DEPTH));
    assign up_ready        = (state_q == IDLE);
    assign dbg_main_state  = state_q;
    assign dbg_drain_state = dstate_q;

    // Drain never starts while a read owns the memory port.
    always_comb begin
        dstate_d    = dstate_q;
        drain_issue = 1'b0;
        pop         = 1'b0;
        case (dstate_q)
            D_IDLE: if (!wb_empty && dn_ready && state_q != R_BUSY) begin
                drain_issue = 1'b1;
                dstate_d    = D_BUSY;
            end
            D_BUSY: if (dn_done) begin
                pop      = 1'b1;
                dstate_d = D_IDLE;
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_addr  = up_addr;
        push_data  = up_wdata;
        done_d     = 1'b0;
        latch_hold = 1'b0;
        latch_rd   = 1'b0;
        read_issue = 1'b0;
        capture_rd = 1'b0;
        case (state_q)
            IDLE: if (up_req) begin
                if (up_we) begin
                    if (!wb_full) begin
                        push   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        latch_hold = 1'b1;
                        state_d    = W_FULL;
                    end
                end else begin
                    latch_rd = 1'b1;
                    state_d  = R_WAIT_EMPTY;
                end
            end
            // The popped slot is the one the hold entry lands in, so push and pop pair up.
            W_FULL: if (pop) begin
                push      = 1'b1;
                push_addr = hold_addr_q;
                push_data = hold_data_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            R_WAIT_EMPTY: if (wb_empty && dstate_q == D_IDLE && dn_ready) begin
                read_issue = 1'b1;
                state_d    = R_BUSY;
            end
            R_BUSY: if (dn_done) begin
                capture_rd = 1'b1;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail_q] <= push_addr;
            fifo_data[tail_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dstate_q    <= D_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            rd_addr_q   <= '0;
            up_done     <= 1'b0;
            up_rdata    <= '0;
            dn_req      <= 1'b0;
            dn_we       <= 1'b0;
            dn_addr     <= '0;
            dn_wdata    <= '0;
        end else begin
            state_q  <= state_d;
            dstate_q <= dstate_d;
            up_done  <= done_d;
            dn_req   <= drain_issue || read_issue;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (latch_hold) begin
                hold_addr_q <= up_addr;
                hold_data_q <= up_wdata;
            end
            if (latch_rd)   rd_addr_q <= up_addr;
            if (capture_rd) up_rdata  <= dn_rdata;
            if (drain_issue) begin
                dn_we    <= 1'b1;
                dn_addr  <= fifo_addr[head_q];
                dn_wdata <= fifo_data[head_q];
            end else if (read_issue) begin
                dn_we   <= 1'b0;
                dn_addr <= rd_addr_q;
            end
        end
    end

endmodule

// File: doc/write_buffer.md
# write_buffer

Posted-write FIFO between the cache's memory port and `main_memory`. It acknowledges write-through and write-bypass stores as soon as they are queued, and drains them to memory in order, one at a time. Reads (refill words) are held until every queued write has been committed, then forwarded to memory. Memory ordering is preserved without address compare.

## Interface
- `ADDR_W`, 16: address width (word address as issued by cache).
- `DATA_W`, 32: data width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PTR_W`, 2: log2(`DEPTH`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `up_req`  in  1  request from cache; sampled only when `up_ready`=1.
- `up_we`  in  1  1 = write, 0 = read.
- `up_addr`  in  ADDR_W  request address.
- `up_wdata`  in  DATA_W  write data.
- `up_ready`  out  1  combinational; 1 iff FSM in IDLE.
- `up_done`  out  1  registered one-cycle completion pulse.
- `up_rdata`  out  DATA_W  read data; valid with `up_done` after a read, held until the next read completes.
- `dn_req`  out  1  registered one-cycle request to memory.
- `dn_we`  out  1  write enable to memory.
- `dn_addr`  out  ADDR_W  memory address.
- `dn_wdata`  out  DATA_W  memory write data.
- `dn_ready`  in  1  memory idle.
- `dn_done`  in  1  memory completion pulse.
- `dn_rdata`  in  DATA_W  memory read data, valid with `dn_done`.
- `wb_count`  out  PTR_W+1  queued entries.
- `wb_empty`, `wb_full`  out  1  `wb_count`==0 / ==`DEPTH`.

## Operation
- Storage: `DEPTH` × {addr, data}. Head/tail pointers wrap modulo `DEPTH`. The count increments on push and decrements on pop; a push and a pop in the same cycle leave the count unchanged.
- Main FSM states: IDLE, W_FULL, R_WAIT_EMPTY, R_BUSY.
  - **IDLE, write, not full:** push {up_addr, up_wdata}; `up_done`=1 next cycle; stay IDLE. Back-to-back writes are legal.
  - **IDLE, write, full:** latch request into the hold register and go to W_FULL. On the first pop, push the hold entry in that same cycle, pulse `up_done` next cycle, and return to IDLE.
  - **IDLE, read:** latch `up_addr` and go to R_WAIT_EMPTY.
  - **R_WAIT_EMPTY:** when `wb_empty`, drain FSM idle, and `dn_ready`, issue `dn_req`=1, `dn_we`=0, `dn_addr`=latched address, then go to R_BUSY.
  - **R_BUSY:** on `dn_done`, capture `up_rdata`←`dn_rdata`, pulse `up_done` next cycle, and go to IDLE.
- Drain FSM states: D_IDLE, D_BUSY.
  - **D_IDLE:** if not empty, `dn_ready`=1, and main FSM is not in R_BUSY, issue `dn_req`=1, `dn_we`=1, head addr/data, then go to D_BUSY.
  - **D_BUSY:** on `dn_done`, pop head and go to D_IDLE.
- Arbitration: a read never issues while any write is queued or in flight, so the drain always wins. At most one memory transaction is outstanding.
- `up_req` while `up_ready`=0 is ignored (no queuing, no error).
- Reset mid-operation: FIFO contents, the hold entry, and in-flight transactions are discarded; no `up_done` is generated for them.

## Timing
- Reset values:
  - `dn_req`, `dn_we`, `up_done`, `wb_full`, `wb_count` = 0; `wb_empty` = 1.
  - `dn_addr`, `dn_wdata`, `up_rdata` = 0.
  - `up_ready` = 1 (FSM in IDLE).
- Write ack latency: `up_req` sampled at edge of cycle 0 → `up_done`=1 in cycle 1, when not full.
- Drain: the entry pushed in cycle 0 is visible in cycle 1. `dn_req` is high in cycle 2 if `dn_ready`. The next drain issue comes no earlier than the cycle after `dn_done`.
- Read with empty buffer and idle memory: `up_req` cycle 0 → `dn_req` cycle 2 → `up_done` exactly one cycle after `dn_done`.
- `dn_req` is high for exactly one cycle per transaction. `dn_addr`, `dn_wdata`, and `dn_we` are held until the next issue.
- `up_done` is high for exactly one cycle per accepted request.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs take their reset values immediately; `wb_empty`=1 and `up_ready`=1 after release.
- **Single write:** addr 0x0040, data 0xDEADBEEF → `up_done` in cycle 1 and `dn_req`/`dn_we`=1 in cycle 2 at 0x0040. After `dn_done`, mem[0x0040]=0xDEADBEEF and `wb_empty`=1.
- **Overflow:** memory LATENCY=4, five back-to-back writes to 0x0100..0x0104 → first four ack in consecutive cycles and `wb_full`=1. The fifth ack comes one cycle after the first write's `dn_done`. Memory is written in order 0x0100..0x0104.
- **Read after write:** write 0x0010=0x00001234, then immediately read 0x0010 → read `dn_req` is not issued before `wb_empty`=1 and the write's `dn_done`. `up_rdata`=0x00001234 with `up_done`.
- **Cold read, empty buffer:** read 0x0020 with mem[0x0020]=0xCAFEF00D → `dn_req` in cycle 2; `up_done` and `up_rdata`=0xCAFEF00D one cycle after `dn_done`.
- **Reset during drain:** three queued writes, `rst` pulsed while D_BUSY → `wb_count`=0, no `up_done` or `dn_req` afterwards until a new request arrives.
